// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
// Signed support is controlled by the DIV_SIGNED_EN macro in div.sv.
package div_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;
    localparam int CNT_W          = 6;

    localparam logic [CNT_W-1:0] ITER_LAST = 6'd32;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] negate(input logic [REG_BUS-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, fixed latency.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    // Handshake: start_i is held high by EX from request until it has consumed
    // the result; ready_o/result_o are valid only in DIV_END and drop one edge
    // after start_i falls. annul_i aborts an operation in progress.

    div_state_e state;
    div_state_e state_next;

    logic [CNT_W-1:0]          cnt;
    logic [64:0]               dividend;
    logic [REG_BUS-1:0]        divisor;
    logic [DOUBLE_REG_BUS-1:0] result_q;

    logic [REG_BUS:0]   div_temp;
    logic [REG_BUS-1:0] op1_mag;
    logic [REG_BUS-1:0] op2_mag;
    logic [REG_BUS-1:0] quo_fix;
    logic [REG_BUS-1:0] rem_fix;
    logic               accept;
    logic               load_op;

`ifdef DIV_SIGNED_EN
    logic dvd_neg;
    logic quo_neg;

    assign op1_mag = (signed_div_i && opdata1_i[31]) ? negate(opdata1_i) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[31]) ? negate(opdata2_i) : opdata2_i;
    assign quo_fix = quo_neg ? negate(dividend[31:0])  : dividend[31:0];
    assign rem_fix = dvd_neg ? negate(dividend[64:33]) : dividend[64:33];
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div_i;
    assign op1_mag = opdata1_i;
    assign op2_mag = opdata2_i;
    assign quo_fix = dividend[31:0];
    assign rem_fix = dividend[64:33];
`endif

    // Trial subtraction of the divisor from the current partial remainder.
    assign div_temp = {1'b0, dividend[63:32]} - {1'b0, divisor};

    assign accept  = (state == DIV_FREE) && (start_i == DIV_START) && !annul_i;
    assign load_op = accept && (opdata2_i != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                state_next = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_next = DIV_FREE;
                end else if (cnt == ITER_LAST) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            result_q <= '0;
`ifdef DIV_SIGNED_EN
            dvd_neg  <= 1'b0;
            quo_neg  <= 1'b0;
`endif
        end else begin
            case (state)
                DIV_FREE: begin
                    if (load_op) begin
                        // Dividend sits in [32:1] so the first window sees its MSB.
                        dividend <= {32'd0, op1_mag, 1'b0};
                        divisor  <= op2_mag;
                        cnt      <= '0;
`ifdef DIV_SIGNED_EN
                        dvd_neg  <= signed_div_i & opdata1_i[31];
                        quo_neg  <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
`endif
                    end
                end
                DIV_BY_ZERO: begin
                    result_q <= '0;
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        if (cnt != ITER_LAST) begin
                            if (div_temp[32]) begin
                                dividend <= {dividend[63:0], 1'b0};
                            end else begin
                                dividend <= {div_temp[31:0], dividend[31:0], 1'b1};
                            end
                            cnt <= cnt + 6'd1;
                        end else begin
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign result_o = (state == DIV_END) ? result_q : '0;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases from the test plan plus random
// operands compared against an arithmetic reference model.
module tb_div;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic, HI = remainder, LO = quotient.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
`else
        if (sgn) begin
            // signed request is treated as unsigned in this build
        end
`endif
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Driver: call with time away from posedge (after a negedge).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold);
        logic [63:0] exp;
        int n;
        exp        = ref_div(a, b, sgn);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        @(posedge clk);  // E0
        #1;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ready_o && n < 100);
        check("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
        check("ready_high", 64'(ready_o), 64'd1);
        check("result", result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
        check("drop_state", 64'(dut.state), 64'(DIV_FREE));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_state", 64'(dut.state), 64'(DIV_FREE));
        check("rst_cnt", 64'(dut.cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_div(32'd100, 32'd7, 1'b0, 2);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div(32'd5, 32'd0, 1'b0, 1);
        run_div(32'd100, 32'd7, 1'b0, 0);

        // annul at E10, new start sampled at E12
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        start   = 1'b1;
        @(posedge clk);  // E0
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("annul_busy_ready", 64'(ready_o), 64'd0);
        end
        start = 1'b0;
        annul = 1'b1;
        @(posedge clk);  // E10
        @(negedge clk);
        annul = 1'b0;
        check("annul_state", 64'(dut.state), 64'(DIV_FREE));
        check("annul_ready", 64'(ready_o), 64'd0);
        @(posedge clk);  // E11
        @(negedge clk);
        check("annul_idle_ready", 64'(ready_o), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 0);

        // reset at E20 mid-divide
        opdata1 = 32'd1000;
        opdata2 = 32'd7;
        start   = 1'b1;
        @(posedge clk);  // E0
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);  // E20
        @(negedge clk);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_state", 64'(dut.state), 64'(DIV_FREE));
        rst = 1'b0;
        run_div(32'd12345, 32'd67, 1'b0, 1);

        // random operands, occasional zero divisor and small divisors
        for (int k = 0; k < 30; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
